hand_dealer: RTL and testbench

HAND_DEALER -- requirements
Module: hand_dealer

---
 rtl/card_pkg.sv | 35 +++
 rtl/card_counter.sv | 20 ++
 rtl/hand_dealer.sv | 100 ++++++++++
 tb/tb_hand_dealer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// card_pkg -- shared definitions for the hand dealer.
//   dealState_t : dealer FSM states (IDLE, SCORE, FULL)
//   CARD_MIN/CARD_MAX : range of the card code (A=1 .. K=13)
//   MAX_CARDS   : hand capacity
//   card_value  : card code -> scoring value 0..9 (10/J/Q/K count as 0)
//   mod10       : reduce a 0..27 hand sum to a 0..9 score
package card_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCORE,
    FULL
  } dealState_t;

  localparam logic [3:0] CARD_MIN  = 4'd1;
  localparam logic [3:0] CARD_MAX  = 4'd13;
  localparam logic [1:0] MAX_CARDS = 2'd3;

  function automatic logic [3:0] card_value(input logic [3:0] cardCode);
    logic [3:0] v;
    v = '0;
    if (cardCode >= 4'd1 && cardCode <= 4'd9) v = cardCode;
    return v;
  endfunction

  // Sum never exceeds 27, so two conditional subtractions are enough.
  function automatic logic [3:0] mod10(input logic [4:0] sum);
    logic [4:0] r;
    if (sum >= 5'd20)      r = sum - 5'd20;
    else if (sum >= 5'd10) r = sum - 5'd10;
    else                   r = sum;
    return r[3:0];
  endfunction

endpackage

// File: rtl/card_counter.sv
// card_counter -- free-running draw counter cycling CARD_MIN..CARD_MAX.
//   clock  : rising-edge clock
//   resetb : asynchronous active-low reset, loads CARD_MIN
//   out    : current draw value, always 1..13
module card_counter
  import card_pkg::*;
(
  input  logic       clock,
  input  logic       resetb,
  output logic [3:0] out
);

  // ">=" also pulls any out-of-range value back into the cycle.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb)              out <= CARD_MIN;
    else if (out >= CARD_MAX) out <= CARD_MIN;
    else                      out <= out + 4'd1;
  end

endmodule

// File: rtl/hand_dealer.sv
// hand_dealer -- deals up to three cards from a free-running draw counter
// and keeps a mod-10 hand score.
//   clock, resetb : rising-edge clock, asynchronous active-low reset
//   deal_req      : level-sampled request to draw one card
//   hand_clear    : empty the hand (wins over deal_req)
//   card_valid    : one-cycle pulse when new card and score are stable
//   card          : last dealt card (0 = none)
//   slot1..slot3  : held cards, 0 = empty; same code as the 7-seg decoders
//   card_count    : cards held, 0..3
//   score         : hand score 0..9
//   hand_full     : card_count == 3
//   deal_err      : one-cycle pulse for a request refused on a full hand
module hand_dealer
  import card_pkg::*;
(
  input  logic       clock,
  input  logic       resetb,
  input  logic       deal_req,
  input  logic       hand_clear,
  output logic       card_valid,
  output logic [3:0] card,
  output logic [3:0] slot1,
  output logic [3:0] slot2,
  output logic [3:0] slot3,
  output logic [1:0] card_count,
  output logic [3:0] score,
  output logic       hand_full,
  output logic       deal_err
);

  dealState_t state;
  logic [3:0] drawCard;
  logic [4:0] scoreSum;

  card_counter drawCounter (
    .clock  (clock),
    .resetb (resetb),
    .out    (drawCard)
  );

  // Slots are already updated when SCORE is entered, so the sum reads them directly.
  always_comb begin
    scoreSum = 5'(card_value(slot1)) + 5'(card_value(slot2)) + 5'(card_value(slot3));
  end

  // Derived from a register only; no input reaches it combinationally.
  assign hand_full = (card_count == MAX_CARDS);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state      <= IDLE;
      card       <= '0;
      slot1      <= '0;
      slot2      <= '0;
      slot3      <= '0;
      card_count <= '0;
      score      <= '0;
      card_valid <= 1'b0;
      deal_err   <= 1'b0;
    end else begin
      card_valid <= 1'b0;
      deal_err   <= 1'b0;
      if (hand_clear) begin
        state      <= IDLE;
        card       <= '0;
        slot1      <= '0;
        slot2      <= '0;
        slot3      <= '0;
        card_count <= '0;
        score      <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (deal_req) begin
              card <= drawCard;
              case (card_count)
                2'd0:    slot1 <= drawCard;
                2'd1:    slot2 <= drawCard;
                2'd2:    slot3 <= drawCard;
                default: ;
              endcase
              card_count <= card_count + 2'd1;
              state      <= SCORE;
            end
          end
          SCORE: begin
            score      <= mod10(scoreSum);
            card_valid <= 1'b1;
            state      <= (card_count == MAX_CARDS) ? FULL : IDLE;
          end
          FULL: begin
            if (deal_req) deal_err <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hand_dealer.sv
module tb_hand_dealer;
  import card_pkg::*;

  logic       clock = 1'b0;
  logic       resetb = 1'b0;
  logic       deal_req = 1'b0;
  logic       hand_clear = 1'b0;
  logic       card_valid;
  logic [3:0] card, slot1, slot2, slot3, score;
  logic [1:0] card_count;
  logic       hand_full, deal_err;

  hand_dealer dut (
    .clock      (clock),
    .resetb     (resetb),
    .deal_req   (deal_req),
    .hand_clear (hand_clear),
    .card_valid (card_valid),
    .card       (card),
    .slot1      (slot1),
    .slot2      (slot2),
    .slot3      (slot3),
    .card_count (card_count),
    .score      (score),
    .hand_full  (hand_full),
    .deal_err   (deal_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a hand is a queue of card codes; a dealt card is
  // scored on the edge after it is taken.
  int mCnt = 1;
  int mHand[$];
  int mCard = 0;
  int mScore = 0;
  bit mPending = 0;
  bit mValid = 0;
  bit mErr = 0;

  function automatic int cval(input int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  function automatic int mSlot(input int i);
    return (i < mHand.size()) ? mHand[i] : 0;
  endfunction

  task automatic modelReset();
    mCnt = 1; mHand.delete(); mCard = 0; mScore = 0;
    mPending = 0; mValid = 0; mErr = 0;
  endtask

  always @(negedge resetb) modelReset();

  always @(posedge clock) begin : modelStep
    int drawn;
    int s;
    if (!resetb) modelReset();
    else begin
      drawn = mCnt;
      mCnt = (mCnt == 13) ? 1 : mCnt + 1;
      mValid = 0;
      mErr = 0;
      if (hand_clear) begin
        mHand.delete(); mCard = 0; mScore = 0; mPending = 0;
      end else if (mPending) begin
        s = 0;
        foreach (mHand[i]) s += cval(mHand[i]);
        mScore = s % 10;
        mValid = 1;
        mPending = 0;
      end else if (mHand.size() == 3) begin
        if (deal_req) mErr = 1;
      end else if (deal_req) begin
        mHand.push_back(drawn);
        mCard = drawn;
        mPending = 1;
      end
    end
  end

  always @(negedge clock) begin
    chk("card", card, mCard);
    chk("slot1", slot1, mSlot(0));
    chk("slot2", slot2, mSlot(1));
    chk("slot3", slot3, mSlot(2));
    chk("count", card_count, mHand.size());
    chk("score", score, mScore);
    chk("valid", card_valid, mValid);
    chk("err", deal_err, mErr);
    chk("full", hand_full, (mHand.size() == 3) ? 1 : 0);
    chk("counter", dut.drawCard, mCnt);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  // Advance until the next edge will draw value v (bounded).
  task automatic waitFor(input int v);
    int k;
    k = 0;
    while (mCnt != v && k < 30) begin
      tick();
      k++;
    end
    if (mCnt != v) chk("wait_counter_timeout", mCnt, v);
  endtask

  task automatic dealOne();
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    tick();
  endtask

  initial begin
    int errPulses;

    // Reset held
    tick(3);
    chk("rst_card", card, 0);
    chk("rst_count", card_count, 0);
    chk("rst_valid", card_valid, 0);
    chk("rst_full", hand_full, 0);
    chk("rst_counter", dut.drawCard, 1);
    resetb = 1'b1;
    tick();
    chk("rel_counter", dut.drawCard, 2);

    // Single deal at counter 7
    waitFor(7);
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    chk("single_card", card, 7);
    chk("single_slot1", slot1, 7);
    chk("single_count", card_count, 1);
    chk("single_valid_early", card_valid, 0);
    tick();
    chk("single_valid", card_valid, 1);
    chk("single_score", score, 7);
    tick();
    chk("single_valid_end", card_valid, 0);
    hand_clear = 1'b1;
    tick();
    hand_clear = 1'b0;

    // Three deals: 9, 13, 4
    waitFor(9);  dealOne();
    waitFor(13); dealOne();
    waitFor(4);  dealOne();
    chk("three_slot1", slot1, 9);
    chk("three_slot2", slot2, 13);
    chk("three_slot3", slot3, 4);
    chk("three_score", score, 3);
    chk("three_full", hand_full, 1);
    chk("three_state", int'(dut.state), int'(FULL));

    // Requests on a full hand
    errPulses = 0;
    deal_req = 1'b1;
    repeat (3) begin
      tick();
      errPulses += int'(deal_err);
    end
    deal_req = 1'b0;
    chk("full_err_pulses", errPulses, 3);
    chk("full_slot1", slot1, 9);
    chk("full_slot3", slot3, 4);
    tick();
    chk("full_err_end", deal_err, 0);

    // Clear wins over deal with two cards held
    hand_clear = 1'b1;
    tick();
    hand_clear = 1'b0;
    dealOne();
    dealOne();
    chk("prio_pre_count", card_count, 2);
    hand_clear = 1'b1;
    deal_req = 1'b1;
    tick();
    hand_clear = 1'b0;
    deal_req = 1'b0;
    chk("prio_count", card_count, 0);
    chk("prio_slot1", slot1, 0);
    chk("prio_slot2", slot2, 0);
    chk("prio_valid", card_valid, 0);
    chk("prio_err", deal_err, 0);
    tick();
    chk("prio_valid_next", card_valid, 0);

    // Reset during SCORE drops the pending update
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    resetb = 1'b0;
    tick();
    resetb = 1'b1;
    repeat (3) begin
      tick();
      chk("rst_score_valid", card_valid, 0);
    end

    // Counter wrap over 26 values
    resetb = 1'b0;
    tick();
    resetb = 1'b1;
    for (int i = 0; i < 26; i++) begin
      chk("wrap", dut.drawCard, (i % 13) + 1);
      tick();
    end

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      deal_req = 1'($urandom_range(0, 1));
      hand_clear = ($urandom_range(0, 19) == 0);
      if (resetb && $urandom_range(0, 99) == 0) resetb = 1'b0;
      else if (!resetb && $urandom_range(0, 2) == 0) resetb = 1'b1;
      tick();
    end

    deal_req = 1'b0;
    hand_clear = 1'b0;
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
